// File: rtl/ledddc_pkg.sv
// -----------------------------------------------------------------------------
// ledddc_pkg
// Shared definitions for the LED display driver frame-buffer bank scheduler:
//   - default SRAM geometry (AW_DEF / DW_DEF) and frame counter width
//   - scheduler state encoding
//   - bank index constants
// -----------------------------------------------------------------------------
package ledddc_pkg;

    localparam int AW_DEF  = 9;     // 512 words per bank
    localparam int DW_DEF  = 16;    // pixel word width
    localparam int FCW_DEF = 4;     // displayed-frame counter width

    // Scheduler states. Kept as plain constants so the encoding is fixed and
    // visible to anything that inspects the state register.
    localparam logic [1:0] ST_FILL_FIRST = 2'd0;
    localparam logic [1:0] ST_RUN        = 2'd1;
    localparam logic [1:0] ST_WAIT_SWAP  = 2'd2;
    localparam logic [1:0] ST_SINGLE     = 2'd3;

    localparam logic BANK0 = 1'b0;
    localparam logic BANK1 = 1'b1;

endpackage

// File: rtl/ledddc_bank_sched_if.sv
// -----------------------------------------------------------------------------
// ledddc_bank_sched_if
// Request-side bus of the bank scheduler.
//   master : writer (DAI deserializer) and reader (scan/PWM) request drivers
//   slave  : the scheduler
// Signals:
//   wr_req / wr_addr / wr_data : one pixel word per wr_req cycle
//   wr_frame_done              : writer finished a full frame
//   rd_req / rd_addr           : one pixel word read per rd_req cycle
//   rd_frame_done              : reader finished displaying a frame
// -----------------------------------------------------------------------------
interface ledddc_bank_sched_if #(
    parameter int AW = 9,
    parameter int DW = 16
);
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_frame_done;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_frame_done;

    modport master (
        output wr_req, wr_addr, wr_data, wr_frame_done,
        output rd_req, rd_addr, rd_frame_done
    );

    modport slave (
        input wr_req, wr_addr, wr_data, wr_frame_done,
        input rd_req, rd_addr, rd_frame_done
    );
endinterface

// File: rtl/ledddc_bank_port.sv
// -----------------------------------------------------------------------------
// ledddc_bank_port
// Registered pin driver for one frame-buffer SRAM bank. The bank claims a
// request only when the request's bank select matches i_bank_id; otherwise
// its enables stay high and address/data stay zero.
// Ports:
//   i_clk, i_rst_n           : clock, synchronous active-low reset
//   i_bank_id                : which bank this instance drives
//   i_rd_en/i_rd_bank/i_rd_addr            : read request and its target bank
//   i_wr_en/i_wr_bank/i_wr_addr/i_wr_data  : write request and its target bank
//   o_cena/o_aa              : read port enable (active low) and address
//   o_cenb/o_ab/o_db         : write port enable (active low), address, data
// -----------------------------------------------------------------------------
module ledddc_bank_port #(
    parameter int AW = 9,
    parameter int DW = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_bank_id,
    input  logic          i_rd_en,
    input  logic          i_rd_bank,
    input  logic [AW-1:0] i_rd_addr,
    input  logic          i_wr_en,
    input  logic          i_wr_bank,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    output logic          o_cena,
    output logic [AW-1:0] o_aa,
    output logic          o_cenb,
    output logic [AW-1:0] o_ab,
    output logic [DW-1:0] o_db
);
    logic          w_rd_hit;
    logic          w_wr_hit;
    logic          r_cena;
    logic [AW-1:0] r_aa;
    logic          r_cenb;
    logic [AW-1:0] r_ab;
    logic [DW-1:0] r_db;

    assign w_rd_hit = i_rd_en && (i_rd_bank == i_bank_id);
    assign w_wr_hit = i_wr_en && (i_wr_bank == i_bank_id);

    // NOTE: state is updated only with non-blocking assignments so every
    // register samples the pre-edge value of its inputs, independent of
    // statement order.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cena <= 1'b1;
            r_aa   <= '0;
            r_cenb <= 1'b1;
            r_ab   <= '0;
            r_db   <= '0;
        end else begin
            // Idle pins are parked at zero so the bank sees no toggling.
            r_cena <= !w_rd_hit;
            r_aa   <= w_rd_hit ? i_rd_addr : '0;
            r_cenb <= !w_wr_hit;
            r_ab   <= w_wr_hit ? i_wr_addr : '0;
            r_db   <= w_wr_hit ? i_wr_data : '0;
        end
    end

    assign o_cena = r_cena;
    assign o_aa   = r_aa;
    assign o_cenb = r_cenb;
    assign o_ab   = r_ab;
    assign o_db   = r_db;
endmodule

// File: rtl/ledddc_bank_sched.sv
// -----------------------------------------------------------------------------
// ledddc_bank_sched
// Ping-pong scheduler for the two 512x16 frame-buffer banks. Writes land in
// bank wb, reads come from the other bank, and the banks swap only on frame
// boundaries agreed by writer and reader. mode = 0 collapses to bank 0 only.
// Ports:
//   GCK, rst        : clock, synchronous active-low reset
//   mode            : 1 = ping-pong, 0 = single bank
//   bus (slave)     : write/read requests and frame_done pulses
//   CENA0/1, AA0/1  : bank read enables (active low) and addresses
//   CENB0/1, AB0/1, DB0/1 : bank write enables (active low), addresses, data
//   rd_sel          : QA mux select, aligned with SRAM read data
//   rd_blank        : no frame displayable yet
//   wr_drop         : a write was discarded while waiting for a swap
//   frame_cnt       : number of completed swaps, wraps silently
// Optional (LEDDC_SCHED_STATS_EN): drop_cnt (saturating drop count),
//   ovf_sticky (set on first drop, cleared only by reset).
// -----------------------------------------------------------------------------
module ledddc_bank_sched
    import ledddc_pkg::*;
#(
    parameter int AW  = AW_DEF,
    parameter int DW  = DW_DEF,
    parameter int FCW = FCW_DEF
) (
    input  logic               GCK,
    input  logic               rst,
    input  logic               mode,
    ledddc_bank_sched_if.slave bus,
    output logic               CENA0,
    output logic               CENA1,
    output logic [AW-1:0]      AA0,
    output logic [AW-1:0]      AA1,
    output logic               CENB0,
    output logic               CENB1,
    output logic [AW-1:0]      AB0,
    output logic [AW-1:0]      AB1,
    output logic [DW-1:0]      DB0,
    output logic [DW-1:0]      DB1,
    output logic               rd_sel,
    output logic               rd_blank,
    output logic               wr_drop,
    output logic [FCW-1:0]     frame_cnt
`ifdef LEDDC_SCHED_STATS_EN
    ,
    output logic [7:0]         drop_cnt,
    output logic               ovf_sticky
`endif
);
    logic [1:0]     r_state;
    logic           r_wb;
    logic           r_rd_blank;
    logic [FCW-1:0] r_frame_cnt;
    logic           r_wr_drop;
    logic           r_rd_v1;
    logic           r_rd_b1;
    logic           r_rd_sel;

    logic [1:0]     w_state_nxt;
    logic           w_wb_nxt;
    logic           w_blank_nxt;
    logic           w_cnt_inc;
    logic           w_single;
    logic           w_wr_en;
    logic           w_wr_bank;
    logic           w_rd_en;
    logic           w_rd_bank;
    logic           w_drop;

    // Steering uses the registered state, so a swap edge only affects
    // requests that arrive in the following cycle.
    assign w_single  = (r_state == ST_SINGLE);
    assign w_wr_en   = bus.wr_req && (r_state != ST_WAIT_SWAP);
    assign w_wr_bank = w_single ? BANK0 : r_wb;
    assign w_rd_en   = bus.rd_req && (r_state != ST_FILL_FIRST);
    assign w_rd_bank = w_single ? BANK0 : !r_wb;
    assign w_drop    = bus.wr_req && (r_state == ST_WAIT_SWAP);

    // NOTE: every output of this block is given a default first, so no path
    // leaves a value unassigned and no latch can be inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_wb_nxt    = r_wb;
        w_blank_nxt = r_rd_blank;
        w_cnt_inc   = 1'b0;
        if (!mode) begin
            // Mode change wins over frame_done; only an established SINGLE
            // state counts displayed frames.
            w_state_nxt = ST_SINGLE;
            w_wb_nxt    = BANK0;
            w_blank_nxt = 1'b0;
            w_cnt_inc   = w_single && bus.rd_frame_done;
        end else if (w_single) begin
            w_state_nxt = ST_FILL_FIRST;
            w_wb_nxt    = BANK0;
            w_blank_nxt = 1'b1;
        end else begin
            case (r_state)
                ST_FILL_FIRST: begin
                    if (bus.wr_frame_done) begin
                        w_state_nxt = ST_RUN;
                        w_wb_nxt    = !r_wb;
                        w_blank_nxt = 1'b0;
                        w_cnt_inc   = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.wr_frame_done && bus.rd_frame_done) begin
                        w_wb_nxt  = !r_wb;
                        w_cnt_inc = 1'b1;
                    end else if (bus.wr_frame_done) begin
                        w_state_nxt = ST_WAIT_SWAP;
                    end
                end
                ST_WAIT_SWAP: begin
                    if (bus.rd_frame_done) begin
                        w_state_nxt = ST_RUN;
                        w_wb_nxt    = !r_wb;
                        w_cnt_inc   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge GCK) begin
        if (!rst) begin
            r_state     <= ST_FILL_FIRST;
            r_wb        <= BANK0;
            r_rd_blank  <= 1'b1;
            r_frame_cnt <= '0;
            r_wr_drop   <= 1'b0;
            r_rd_v1     <= 1'b0;
            r_rd_b1     <= BANK0;
            r_rd_sel    <= BANK0;
        end else begin
            r_state     <= w_state_nxt;
            r_wb        <= w_wb_nxt;
            r_rd_blank  <= w_blank_nxt;
            r_frame_cnt <= r_frame_cnt + FCW'(w_cnt_inc);
            r_wr_drop   <= w_drop;
            // Two-stage select pipe: stage 1 lines up with CENA, stage 2
            // with QA. rd_sel holds its last value between reads.
            r_rd_v1     <= w_rd_en;
            r_rd_b1     <= w_rd_bank;
            if (r_rd_v1) begin
                r_rd_sel <= r_rd_b1;
            end
        end
    end

    ledddc_bank_port #(.AW(AW), .DW(DW)) u_port0 (
        .i_clk     (GCK),
        .i_rst_n   (rst),
        .i_bank_id (BANK0),
        .i_rd_en   (w_rd_en),
        .i_rd_bank (w_rd_bank),
        .i_rd_addr (bus.rd_addr),
        .i_wr_en   (w_wr_en),
        .i_wr_bank (w_wr_bank),
        .i_wr_addr (bus.wr_addr),
        .i_wr_data (bus.wr_data),
        .o_cena    (CENA0),
        .o_aa      (AA0),
        .o_cenb    (CENB0),
        .o_ab      (AB0),
        .o_db      (DB0)
    );

    ledddc_bank_port #(.AW(AW), .DW(DW)) u_port1 (
        .i_clk     (GCK),
        .i_rst_n   (rst),
        .i_bank_id (BANK1),
        .i_rd_en   (w_rd_en),
        .i_rd_bank (w_rd_bank),
        .i_rd_addr (bus.rd_addr),
        .i_wr_en   (w_wr_en),
        .i_wr_bank (w_wr_bank),
        .i_wr_addr (bus.wr_addr),
        .i_wr_data (bus.wr_data),
        .o_cena    (CENA1),
        .o_aa      (AA1),
        .o_cenb    (CENB1),
        .o_ab      (AB1),
        .o_db      (DB1)
    );

    assign rd_sel    = r_rd_sel;
    assign rd_blank  = r_rd_blank;
    assign wr_drop   = r_wr_drop;
    assign frame_cnt = r_frame_cnt;

`ifdef LEDDC_SCHED_STATS_EN
    logic [7:0] r_drop_cnt;
    logic       r_ovf_sticky;

    always_ff @(posedge GCK) begin
        if (!rst) begin
            r_drop_cnt   <= '0;
            r_ovf_sticky <= 1'b0;
        end else if (r_wr_drop) begin
            if (r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
            r_ovf_sticky <= 1'b1;
        end
    end

    assign drop_cnt   = r_drop_cnt;
    assign ovf_sticky = r_ovf_sticky;
`endif
endmodule

// File: tb/tb_ledddc_bank_sched.sv
// -----------------------------------------------------------------------------
// tb_ledddc_bank_sched
// Self-checking bench for ledddc_bank_sched. Each cycle's stimulus is driven
// on the falling edge; the expected pin state for the following rising edge
// is computed by an independent reference model and queued, then popped and
// compared 1 time unit after that edge. A vector table covers the RUN /
// WAIT_SWAP behaviour with hand-written expected status, and hand sequences
// cover fill, frame counter wrap, SINGLE mode and reset in WAIT_SWAP.
// Optional ports are exercised when LEDDC_SCHED_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_ledddc_bank_sched;
    localparam int AW  = 9;
    localparam int DW  = 16;
    localparam int FCW = 4;

    logic           GCK = 1'b0;
    logic           rst;
    logic           mode;
    logic           CENA0, CENA1, CENB0, CENB1;
    logic [AW-1:0]  AA0, AA1, AB0, AB1;
    logic [DW-1:0]  DB0, DB1;
    logic           rd_sel, rd_blank, wr_drop;
    logic [FCW-1:0] frame_cnt;
`ifdef LEDDC_SCHED_STATS_EN
    logic [7:0]     drop_cnt;
    logic           ovf_sticky;
`endif

    always #5 GCK = ~GCK;

    ledddc_bank_sched_if #(.AW(AW), .DW(DW)) bus ();

    ledddc_bank_sched #(.AW(AW), .DW(DW), .FCW(FCW)) dut (
        .GCK       (GCK),
        .rst       (rst),
        .mode      (mode),
        .bus       (bus),
        .CENA0     (CENA0),
        .CENA1     (CENA1),
        .AA0       (AA0),
        .AA1       (AA1),
        .CENB0     (CENB0),
        .CENB1     (CENB1),
        .AB0       (AB0),
        .AB1       (AB1),
        .DB0       (DB0),
        .DB1       (DB1),
        .rd_sel    (rd_sel),
        .rd_blank  (rd_blank),
        .wr_drop   (wr_drop),
        .frame_cnt (frame_cnt)
`ifdef LEDDC_SCHED_STATS_EN
        ,
        .drop_cnt  (drop_cnt),
        .ovf_sticky(ovf_sticky)
`endif
    );

    typedef struct {
        logic          mode;
        logic          wr_req;
        logic [AW-1:0] wr_addr;
        logic [DW-1:0] wr_data;
        logic          wfd;
        logic          rd_req;
        logic [AW-1:0] rd_addr;
        logic          rfd;
        logic          x_drop;   // hand-derived expectations for table use
        logic          x_blank;
        logic [3:0]    x_cnt;
    } vec_t;

    typedef struct {
        logic [3:0]      cen;    // {CENA0, CENA1, CENB0, CENB1}
        logic [2*AW-1:0] aa;
        logic [2*AW-1:0] ab;
        logic [2*DW-1:0] db;
        logic            drop;
        logic            blank;
        logic [3:0]      cnt;
        logic [7:0]      drops;
        logic            ovf;
    } exp_t;

    typedef struct {
        int   due;
        logic bank;
    } sel_t;

    typedef enum int {M_FILL, M_RUN, M_WAIT, M_SINGLE} mstate_t;

    exp_t    exp_q[$];
    sel_t    sel_q[$];
    mstate_t m_state;
    logic    m_wb;
    logic    m_blank;
    logic [3:0] m_cnt;
    logic [7:0] m_drops;
    int      cyc;
    int      n_checks;
    int      n_fail;
    int      n_cenb0;
    int      n_cenb1;
    vec_t    tbl[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    function automatic vec_t mk(input logic md, input logic wr, input int wa, input int wd,
                                input logic wfd, input logic rd, input int ra, input logic rfd,
                                input logic xd, input logic xb, input int xc);
        vec_t v;
        v.mode    = md;
        v.wr_req  = wr;
        v.wr_addr = wa[AW-1:0];
        v.wr_data = wd[DW-1:0];
        v.wfd     = wfd;
        v.rd_req  = rd;
        v.rd_addr = ra[AW-1:0];
        v.rfd     = rfd;
        v.x_drop  = xd;
        v.x_blank = xb;
        v.x_cnt   = xc[3:0];
        return v;
    endfunction

    // One clock: drive, predict, wait for the edge, compare.
    task automatic step(input logic r, input vec_t v);
        exp_t e;
        exp_t got;
        logic wr_ok, rd_ok, wbk, rbk, rd0, rd1, wr0, wr1;
        @(negedge GCK);
        rst           = r;
        mode          = v.mode;
        bus.wr_req    = v.wr_req;
        bus.wr_addr   = v.wr_addr;
        bus.wr_data   = v.wr_data;
        bus.wr_frame_done = v.wfd;
        bus.rd_req    = v.rd_req;
        bus.rd_addr   = v.rd_addr;
        bus.rd_frame_done = v.rfd;
        if (!r) begin
            e = '{cen: 4'hF, aa: '0, ab: '0, db: '0, drop: 1'b0, blank: 1'b1,
                  cnt: 4'd0, drops: 8'd0, ovf: 1'b0};
            m_state = M_FILL;
            m_wb    = 1'b0;
            m_blank = 1'b1;
            m_cnt   = 4'd0;
            m_drops = 8'd0;
            sel_q.delete();
        end else begin
            wr_ok = v.wr_req && (m_state != M_WAIT);
            rd_ok = v.rd_req && (m_state != M_FILL);
            wbk   = (m_state == M_SINGLE) ? 1'b0 : m_wb;
            rbk   = (m_state == M_SINGLE) ? 1'b0 : !m_wb;
            rd0   = rd_ok && !rbk;
            rd1   = rd_ok && rbk;
            wr0   = wr_ok && !wbk;
            wr1   = wr_ok && wbk;
            e.cen = {!rd0, !rd1, !wr0, !wr1};
            e.aa  = {rd0 ? v.rd_addr : 9'd0, rd1 ? v.rd_addr : 9'd0};
            e.ab  = {wr0 ? v.wr_addr : 9'd0, wr1 ? v.wr_addr : 9'd0};
            e.db  = {wr0 ? v.wr_data : 16'd0, wr1 ? v.wr_data : 16'd0};
            e.drop = v.wr_req && (m_state == M_WAIT);
            if (rd_ok) sel_q.push_back('{due: cyc + 1, bank: rbk});
            // Stats lag wr_drop by one edge.
            e.drops = m_drops;
            e.ovf   = (m_drops != 8'd0);
            if (e.drop && m_drops != 8'hFF) m_drops = m_drops + 8'd1;
            if (!v.mode) begin
                if (m_state == M_SINGLE && v.rfd) m_cnt = m_cnt + 4'd1;
                m_state = M_SINGLE;
                m_wb    = 1'b0;
                m_blank = 1'b0;
            end else if (m_state == M_SINGLE) begin
                m_state = M_FILL;
                m_wb    = 1'b0;
                m_blank = 1'b1;
            end else if (m_state == M_FILL) begin
                if (v.wfd) begin
                    m_state = M_RUN;
                    m_wb    = !m_wb;
                    m_blank = 1'b0;
                    m_cnt   = m_cnt + 4'd1;
                end
            end else if (m_state == M_RUN) begin
                if (v.wfd && v.rfd) begin
                    m_wb  = !m_wb;
                    m_cnt = m_cnt + 4'd1;
                end else if (v.wfd) begin
                    m_state = M_WAIT;
                end
            end else begin
                if (v.rfd) begin
                    m_state = M_RUN;
                    m_wb    = !m_wb;
                    m_cnt   = m_cnt + 4'd1;
                end
            end
            e.blank = m_blank;
            e.cnt   = m_cnt;
        end
        exp_q.push_back(e);

        @(posedge GCK);
        #1;
        got = exp_q.pop_front();
        check("cen",       64'({CENA0, CENA1, CENB0, CENB1}), 64'(got.cen));
        check("aa",        64'({AA0, AA1}), 64'(got.aa));
        check("ab",        64'({AB0, AB1}), 64'(got.ab));
        check("db",        64'({DB0, DB1}), 64'(got.db));
        check("wr_drop",   64'(wr_drop),   64'(got.drop));
        check("rd_blank",  64'(rd_blank),  64'(got.blank));
        check("frame_cnt", 64'(frame_cnt), 64'(got.cnt));
`ifdef LEDDC_SCHED_STATS_EN
        check("drop_cnt",   64'(drop_cnt),   64'(got.drops));
        check("ovf_sticky", 64'(ovf_sticky), 64'(got.ovf));
`endif
        if (!r) check("rd_sel_reset", 64'(rd_sel), 64'(0));
        while (sel_q.size() > 0 && sel_q[0].due == cyc) begin
            sel_t s;
            s = sel_q.pop_front();
            check("rd_sel", 64'(rd_sel), 64'(s.bank));
        end
        if (!CENB0) n_cenb0++;
        if (!CENB1) n_cenb1++;
        cyc++;
    endtask

    task automatic idle(input logic md);
        step(1'b1, mk(md, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        rst      = 1'b0;
        mode     = 1'b1;
        bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_frame_done = 1'b0;
        bus.rd_req = 1'b0; bus.rd_addr = '0; bus.rd_frame_done = 1'b0;

        // RUN / WAIT_SWAP vectors, starting in RUN with wb = 1, frame_cnt = 1.
        //             md wr  wa   wd       wfd rd  ra  rfd  drop blank cnt
        tbl[0]  = mk(1, 0,  0, 0,       0,  1,  5,  0,   0,   0,    1); // read bank 0
        tbl[1]  = mk(1, 0,  0, 0,       0,  0,  0,  0,   0,   0,    1);
        tbl[2]  = mk(1, 1,  7, 'h1234,  0,  0,  0,  0,   0,   0,    1); // write bank 1
        tbl[3]  = mk(1, 0,  0, 0,       0,  0,  0,  1,   0,   0,    1); // rfd alone: no-op
        tbl[4]  = mk(1, 0,  0, 0,       1,  0,  0,  0,   0,   0,    1); // -> WAIT_SWAP
        tbl[5]  = mk(1, 1,  1, 'h1111,  0,  0,  0,  0,   1,   0,    1); // dropped
        tbl[6]  = mk(1, 1,  2, 'h2222,  0,  0,  0,  0,   1,   0,    1); // dropped
        tbl[7]  = mk(1, 1,  3, 'h3333,  0,  1,  9,  0,   1,   0,    1); // dropped, read continues
        tbl[8]  = mk(1, 0,  0, 0,       1,  0,  0,  0,   0,   0,    1); // repeated wfd ignored
        tbl[9]  = mk(1, 0,  0, 0,       0,  0,  0,  1,   0,   0,    2); // swap, wb = 0
        tbl[10] = mk(1, 1,  4, 'hBEEF,  0,  1,  6,  0,   0,   0,    2); // write 0, read 1
        tbl[11] = mk(1, 1,  8, 'h0808,  1,  1, 11,  1,   0,   0,    3); // old banks, swap
        tbl[12] = mk(1, 1,  9, 'h0909,  0,  0,  0,  0,   0,   0,    3); // write bank 1

        // Reset, then fill the first frame into bank 0.
        step(1'b0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        step(1'b0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        check("blank_after_reset", 64'(rd_blank), 64'(1));
        n_cenb0 = 0;
        n_cenb1 = 0;
        for (int i = 0; i < 512; i++) begin
            // Occasional reads during fill must stay suppressed.
            step(1'b1, mk(1, 1, i, i ^ 'hA5A5, (i == 511), (i % 100 == 0), i, 0, 0, 1, 0));
        end
        check("fill_cenb0_pulses", 64'(n_cenb0), 64'(512));
        check("fill_cenb1_pulses", 64'(n_cenb1), 64'(0));
        check("fill_blank", 64'(rd_blank), 64'(0));
        check("fill_cnt", 64'(frame_cnt), 64'(1));

        // Table-driven RUN / WAIT_SWAP vectors.
        for (int i = 0; i < 13; i++) begin
            step(1'b1, tbl[i]);
            check("tbl_drop",  64'(wr_drop),   64'(tbl[i].x_drop));
            check("tbl_blank", 64'(rd_blank),  64'(tbl[i].x_blank));
            check("tbl_cnt",   64'(frame_cnt), 64'(tbl[i].x_cnt));
        end
        idle(1'b1);   // drains the last pending rd_sel check

        // Back-to-back agreed swaps across the frame counter wrap: 3 + 14 = 17 -> 1.
        for (int i = 0; i < 14; i++) begin
            step(1'b1, mk(1, 1, i, i, 1, 1, i, 1, 0, 0, 0));
        end
        check("wrap_cnt", 64'(frame_cnt), 64'(1));

        // SINGLE mode mid-frame.
        idle(1'b0);
        check("single_blank", 64'(rd_blank), 64'(0));
        step(1'b1, mk(0, 1, 10, 'h0A0A, 0, 1, 10, 0, 0, 0, 0)); // same address, bank 0
        step(1'b1, mk(0, 1, 11, 'h0B0B, 0, 1, 12, 1, 0, 0, 0));
        idle(1'b0);
        check("single_cnt", 64'(frame_cnt), 64'(2));
        check("single_cen1", 64'({CENA1, CENB1}), 64'(2'b11));

        // Back to ping-pong: fresh fill, then reset while waiting for a swap.
        idle(1'b1);
        check("refill_blank", 64'(rd_blank), 64'(1));
        step(1'b1, mk(1, 1, 3, 'h0303, 0, 1, 3, 0, 0, 1, 0));
        step(1'b1, mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        check("refill_cnt", 64'(frame_cnt), 64'(3));
        step(1'b1, mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));     // -> WAIT_SWAP
        step(1'b1, mk(1, 1, 5, 'h0505, 0, 1, 5, 0, 0, 0, 0));
        check("wait_drop", 64'(wr_drop), 64'(1));
        step(1'b0, mk(1, 1, 6, 'h0606, 0, 1, 6, 1, 0, 1, 0));
        check("rst_cens", 64'({CENA0, CENA1, CENB0, CENB1}), 64'(4'hF));
        check("rst_blank", 64'(rd_blank), 64'(1));
        check("rst_cnt", 64'(frame_cnt), 64'(0));
        // FILL_FIRST after reset: writes go to bank 0, reads suppressed.
        step(1'b1, mk(1, 1, 1, 'h0101, 0, 1, 1, 0, 0, 1, 0));
        check("rst_fill_write", 64'({CENA0, CENA1, CENB0, CENB1}), 64'(4'b1101));
        idle(1'b1);

        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ledddc_bank_sched.md
Name: ledddc_bank_sched

Overview:
- Ping-pong scheduler for the two 512x16 frame-buffer SRAM banks of the LED display driver.
- Accepts pixel-word write requests from the DAI deserializer side and read requests from the scan/PWM side.
- Steers each request to the correct bank and drives the SRAM pins (CEN, address, data).
- Swaps banks only at frame boundaries agreed by both sides. It never lets the reader see the bank being written.

Parameters:
- AW, 9, SRAM address width (512 words).
- DW, 16, SRAM data width.
- FCW, 4, width of displayed-frame counter.

Ports:
- GCK  in  1  single clock for the block and both SRAM ports.
- rst  in  1  synchronous, active-low reset.
- mode  in  1  1 = double-buffered (ping-pong), 0 = single-bank (bank 0 only).
- wr_req  in  1  write-word strobe, one cycle per word.
- wr_addr  in  AW  write word address.
- wr_data  in  DW  write word data.
- wr_frame_done  in  1  pulse: writer has finished a full frame (last word may coincide).
- rd_req  in  1  read-word strobe.
- rd_addr  in  AW  read word address.
- rd_frame_done  in  1  pulse: reader has finished displaying a frame (end of 32nd scanline).
- CENA0, CENA1  out  1  bank read enables, active low.
- AA0, AA1  out  AW  bank read addresses.
- CENB0, CENB1  out  1  bank write enables, active low.
- AB0, AB1  out  AW  bank write addresses.
- DB0, DB1  out  DW  bank write data.
- rd_sel  out  1  QA mux select (0 = QA0, 1 = QA1), aligned with SRAM read data.
- rd_blank  out  1  no valid frame yet; the scan side must output zeros.
- wr_drop  out  1  pulse: a write request was discarded.
- frame_cnt  out  FCW  count of completed swaps; wraps modulo 2^FCW.

Behaviour:
- Reset (rst = 0 at a GCK edge):
  - all CEN outputs = 1; all AA/AB/DB = 0.
  - rd_sel = 0, rd_blank = 1, wr_drop = 0, frame_cnt = 0.
  - state = FILL_FIRST, write bank wb = 0.
- Request latency: SRAM pins are registered, 1 cycle after the request.
  - With no request, CEN = 1 and the address/data outputs are 0.
- rd_sel is the read bank of a request delayed 2 cycles, matching the SRAM data latency of QA (one edge after CENA).
- State machine:
  - FILL_FIRST:
    - Writes go to bank wb; rd_blank = 1; reads are suppressed (CENA0 = CENA1 = 1).
    - wr_frame_done -> wb toggles, frame_cnt++, rd_blank = 0, go to RUN.
  - RUN:
    - Writes go to bank wb; reads go to bank ~wb.
    - wr_frame_done together with rd_frame_done in the same cycle -> swap (wb toggles, frame_cnt++), stay in RUN.
    - wr_frame_done alone -> go to WAIT_SWAP.
    - rd_frame_done alone -> no action.
  - WAIT_SWAP:
    - Reads continue from ~wb.
    - Every wr_req is discarded (CENB held 1) and produces a 1-cycle wr_drop pulse in the cycle after the request.
    - rd_frame_done -> swap, frame_cnt++, go to RUN.
    - A repeated wr_frame_done is ignored.
  - SINGLE (active whenever mode = 0):
    - Writes and reads both go to bank 0; bank 1 CENs are held 1.
    - rd_blank = 0; frame_cnt increments on each rd_frame_done.
- Mode changes:
  - mode 1 -> 0 from any state: go to SINGLE on the next edge.
  - mode 0 -> 1: go to FILL_FIRST with wb = 0 and rd_blank = 1.
  - A mode change takes priority over frame_done events in the same cycle.
- Swap timing: a swap takes effect for requests arriving in the cycle after the swap edge.
  - A wr_req in the same cycle as wr_frame_done is written to the old bank.
  - An rd_req in the same cycle as a swap is read from the old bank.
- Read and write to the same address use different physical ports/banks in RUN.
  - In SINGLE mode, same-address read/write behaviour follows the SRAM (read returns old data); the scheduler does not intervene.
- The frame_cnt wrap from 2^FCW-1 to 0 is silent.

Optional Feature:
- Macro: LEDDC_SCHED_STATS_EN.
- When defined, adds two outputs:
  - drop_cnt [7:0]: saturating count of wr_drop pulses.
  - ovf_sticky: set on the first drop, cleared only by reset.
- When undefined, neither port exists and behaviour is otherwise identical.

Decomposition:
- Shared package ledddc_pkg holds:
  - state encoding (FILL_FIRST = 0, RUN = 1, WAIT_SWAP = 2, SINGLE = 3);
  - AW/DW defaults;
  - the bank-index constants.
- One sub-module, ledddc_bank_port: a registered CEN/address/data driver for one bank, instantiated twice with a select input.

Test Plan:
- Reset then mode = 1; 512 writes with wr_addr 0..511; wr_frame_done -> bank 0 CENB pulses 512 times, rd_blank 1 -> 0, wb = 1, frame_cnt = 1.
- RUN; rd_req addr 5 -> CENA0 = 0 and AA0 = 5 one cycle later, CENA1 = 1, rd_sel = 0 two cycles after the request.
- RUN; wr_frame_done with no rd_frame_done; then 3 wr_req -> 3 wr_drop pulses with no CENB activity; rd_frame_done -> swap, frame_cnt = 2, next write goes to bank 0.
- wr_frame_done and rd_frame_done in the same cycle -> immediate swap with no WAIT_SWAP and no drops.
- mode = 0 mid-frame -> SINGLE next edge; reads and writes go to bank 0 only; bank 1 CENs stay 1; rd_blank = 0.
- rst = 0 during WAIT_SWAP -> next edge all CENs = 1, rd_blank = 1, frame_cnt = 0, state FILL_FIRST.
